uart_tx_feeder: RTL

Buffering and launch stage directly upstream of the UART transmitter top. It accepts bytes from the system side into a synchronous FIFO. It then presents them one at a time on p_data with a single-cycle data_valid pulse, pacing itself on the transmitter's busy output so no frame is ever overrun. Single clock domain, same clock as the transmitter.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_tx_feeder.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: feeder FSM encoding and the
// default word width.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with an extra pointer wrap bit; full, empty and level are
// derived from the registered pointers only.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic                  push;
    logic                  pop;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes and launches them one at a time into the UART transmitter,
// pacing on tx_busy. Optional sticky overflow flag: UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      level,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    input  logic                  ovf_clr,
    output logic                  ovf
`endif
);

    feeder_state_t         state;
    feeder_state_t         state_next;
    logic                  launch;
    logic [DATA_WIDTH-1:0] head;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_en   (launch),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Launch only from IDLE; the busy high-then-low handshake must complete
    // before the next word can be popped.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    launch     = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK:  if (tx_busy)  state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data     <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= launch;
            if (launch) p_data <= head;
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                ovf <= 1'b0;
        else if (ovf_clr)        ovf <= 1'b0;
        else if (wr_en && full)  ovf <= 1'b1;
    end
`endif

endmodule
